// File: rtl/rtc_pkg.sv
// Shared definitions for the RTC bus arbiter: FSM encodings,
// requester indices and the default WAIT timeout.
package rtc_pkg;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_GRANT = 3'd1;
    localparam logic [2:0] ST_ISSUE = 3'd2;
    localparam logic [2:0] ST_WAIT  = 3'd3;
    localparam logic [2:0] ST_DONE  = 3'd4;

    localparam int INIT  = 0;
    localparam int USER  = 1;
    localparam int RDPER = 2;

    localparam logic [7:0] TIMEOUT_DEF = 8'd200;

    typedef struct packed {
        logic [7:0] addr;
        logic [7:0] wdata;
        logic       rw;
    } bus_cmd_t;

endpackage

// File: rtl/rtc_rr_select.sv
// Combinational winner select: init machine has absolute priority,
// user and periodic-read machines share by round robin.
module rtc_rr_select
    import rtc_pkg::*;
(
    input  logic [2:0] req,
    input  logic       fav_user,
    output logic [2:0] win
);

    always_comb begin
        win = 3'b000;
        if (req[INIT]) begin
            win[INIT] = 1'b1;
        end else if (req[USER] && req[RDPER]) begin
            if (fav_user) begin
                win[USER] = 1'b1;
            end else begin
                win[RDPER] = 1'b1;
            end
        end else if (req[USER]) begin
            win[USER] = 1'b1;
        end else if (req[RDPER]) begin
            win[RDPER] = 1'b1;
        end
    end

endmodule

// File: rtl/rtc_bus_arbiter.sv
// Arbitrates three RTC register-access machines onto a single
// bus driver, with a bounded wait for driver completion.
module rtc_bus_arbiter
    import rtc_pkg::*;
#(
    parameter logic [7:0] TIMEOUT = TIMEOUT_DEF
)
(
    input  logic       clk,
    input  logic       reset,
    input  logic [2:0] req,
    input  logic [7:0] addr0,
    input  logic [7:0] addr1,
    input  logic [7:0] addr2,
    input  logic [7:0] wdata0,
    input  logic [7:0] wdata1,
    input  logic [7:0] wdata2,
    input  logic       rw0,
    input  logic       rw1,
    input  logic       rw2,
    output logic [2:0] gnt,
    output logic [2:0] done,
    output logic       err,
    output logic [7:0] rdata,
    output logic       bus_start,
    output logic [7:0] bus_addr,
    output logic [7:0] bus_wdata,
    output logic       bus_rw,
    input  logic       bus_fin,
    input  logic [7:0] bus_rdata
);

    logic [2:0] state;
    logic [2:0] win_q;
    logic [2:0] sel;
    logic       fav_user;
    logic [7:0] cnt;
    logic       tmo_hit;
    bus_cmd_t   cmd_sel;

    rtc_rr_select u_sel (
        .req      (req),
        .fav_user (fav_user),
        .win      (sel)
    );

    always_comb begin
        cmd_sel = '0;
        unique case (1'b1)
            sel[INIT]:  cmd_sel = '{addr0, wdata0, rw0};
            sel[USER]:  cmd_sel = '{addr1, wdata1, rw1};
            sel[RDPER]: cmd_sel = '{addr2, wdata2, rw2};
            default:    cmd_sel = '0;
        endcase
    end

    // Leave WAIT once TIMEOUT cycles have been spent there.
    assign tmo_hit = ({1'b0, cnt} + 9'd1) >= {1'b0, TIMEOUT};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= ST_IDLE;
            win_q     <= 3'b000;
            fav_user  <= 1'b1;
            cnt       <= 8'd0;
            err       <= 1'b0;
            rdata     <= 8'd0;
            bus_addr  <= 8'd0;
            bus_wdata <= 8'd0;
            bus_rw    <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (|req) begin
                        state     <= ST_GRANT;
                        win_q     <= sel;
                        bus_addr  <= cmd_sel.addr;
                        bus_wdata <= cmd_sel.wdata;
                        bus_rw    <= cmd_sel.rw;
                    end
                end
                ST_GRANT: begin
                    state <= ST_ISSUE;
                end
                ST_ISSUE: begin
                    cnt   <= 8'd0;
                    state <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (bus_fin) begin
                        state <= ST_DONE;
                        err   <= 1'b0;
                        if (!bus_rw) begin
                            rdata <= bus_rdata;
                        end
                    end else if (tmo_hit) begin
                        state <= ST_DONE;
                        err   <= 1'b1;
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                    err   <= 1'b0;
                    if (win_q[USER]) begin
                        fav_user <= 1'b0;
                    end else if (win_q[RDPER]) begin
                        fav_user <= 1'b1;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    err   <= 1'b0;
                end
            endcase
        end
    end

    always_comb begin
        gnt = 3'b000;
        if (state == ST_GRANT ||
            state == ST_ISSUE ||
            state == ST_WAIT) begin
            gnt = win_q;
        end
    end

    assign done      = (state == ST_DONE) ? win_q : 3'b000;
    assign bus_start = (state == ST_ISSUE);

endmodule

// File: tb/tb_rtc_bus_arbiter.sv
// Randomized self-checking bench for rtc_bus_arbiter against a
// transaction-level model of arbitration, timing and read data.
module tb_rtc_bus_arbiter;

    localparam int TMO = 200;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [2:0] req = 3'b000;
    logic [7:0] addr_a [3];
    logic [7:0] wdata_a [3];
    logic       rw_a [3];
    logic       bus_fin = 1'b0;
    logic [7:0] bus_rdata = 8'd0;

    logic [2:0] gnt;
    logic [2:0] done;
    logic       err;
    logic [7:0] rdata;
    logic       bus_start;
    logic [7:0] bus_addr;
    logic [7:0] bus_wdata;
    logic       bus_rw;

    int errs = 0;
    int checks = 0;

    // Model state: who the shared slot favours, and last read value.
    int         fav_user = 1;
    logic [7:0] exp_rdata = 8'd0;

    always #5 clk = ~clk;

    rtc_bus_arbiter dut (
        .clk       (clk),
        .reset     (reset),
        .req       (req),
        .addr0     (addr_a[0]),
        .addr1     (addr_a[1]),
        .addr2     (addr_a[2]),
        .wdata0    (wdata_a[0]),
        .wdata1    (wdata_a[1]),
        .wdata2    (wdata_a[2]),
        .rw0       (rw_a[0]),
        .rw1       (rw_a[1]),
        .rw2       (rw_a[2]),
        .gnt       (gnt),
        .done      (done),
        .err       (err),
        .rdata     (rdata),
        .bus_start (bus_start),
        .bus_addr  (bus_addr),
        .bus_wdata (bus_wdata),
        .bus_rw    (bus_rw),
        .bus_fin   (bus_fin),
        .bus_rdata (bus_rdata)
    );

    function automatic int pick(input logic [2:0] r);
        if (r[0]) return 0;
        if (r[1] && r[2]) return (fav_user != 0) ? 1 : 2;
        return r[1] ? 1 : 2;
    endfunction

    // One full transaction starting at an IDLE-cycle negedge; ends
    // at the negedge of the IDLE cycle following done.
    // fin_dly <= 0 means the driver never finishes.
    task automatic drive_txn(input logic [2:0] r,
                             input logic [2:0] r_after,
                             input int fin_dly,
                             input logic [7:0] rd,
                             input logic stray);
        int         w;
        int         lim;
        int         bad;
        logic [2:0] oh;
        logic [7:0] ea;
        logic [7:0] ew;
        logic       er;
        logic       exp_err;
        w   = pick(r);
        oh  = 3'b001 << w;
        ea  = addr_a[w];
        ew  = wdata_a[w];
        er  = rw_a[w];
        bad = 0;
        req = r;
        @(negedge clk);
        if (stray) bus_fin = 1'b1;
        checks++;
        if (gnt !== oh || bus_start !== 1'b0 || bus_addr !== ea) begin
            errs++;
            $display("FAIL grant: gnt=%b start=%b addr=%h exp gnt=%b start=0 addr=%h",
                     gnt, bus_start, bus_addr, oh, ea);
        end
        @(negedge clk);
        checks++;
        if (bus_start !== 1'b1 || bus_addr !== ea ||
            bus_wdata !== ew || bus_rw !== er) begin
            errs++;
            $display("FAIL issue: start=%b addr=%h wd=%h rw=%b exp 1 %h %h %b",
                     bus_start, bus_addr, bus_wdata, bus_rw, ea, ew, er);
        end
        req = r_after;
        addr_a[w]  = 8'($urandom);
        wdata_a[w] = 8'($urandom);
        rw_a[w]    = 1'($urandom);
        lim = (fin_dly > 0) ? fin_dly : TMO;
        for (int i = 1; i <= lim; i++) begin
            @(negedge clk);
            bus_fin   = (fin_dly > 0) && (i == fin_dly);
            bus_rdata = (fin_dly > 0 && i == fin_dly) ? rd : 8'($urandom);
            if (done !== 3'b000 || gnt !== oh || bus_start !== 1'b0 ||
                bus_addr !== ea)
                bad++;
        end
        checks++;
        if (bad != 0) begin
            errs++;
            $display("FAIL wait: %0d bad cycles, exp 0 (gnt exp %b)", bad, oh);
        end
        @(negedge clk);
        bus_fin = 1'b0;
        exp_err = (fin_dly <= 0);
        if (!exp_err && !er) exp_rdata = rd;
        checks++;
        if (done !== oh || err !== exp_err || rdata !== exp_rdata ||
            gnt !== 3'b000 || bus_addr !== ea || bus_wdata !== ew) begin
            errs++;
            $display("FAIL done: done=%b err=%b rdata=%h gnt=%b addr=%h exp %b %b %h 000 %h",
                     done, err, rdata, gnt, bus_addr, oh, exp_err, exp_rdata, ea);
        end
        if (w == 1) fav_user = 0;
        else if (w == 2) fav_user = 1;
        @(negedge clk);
        checks++;
        if (done !== 3'b000 || err !== 1'b0 || gnt !== 3'b000 ||
            bus_start !== 1'b0 || rdata !== exp_rdata) begin
            errs++;
            $display("FAIL idle: done=%b err=%b gnt=%b start=%b rdata=%h exp 000 0 000 0 %h",
                     done, err, gnt, bus_start, rdata, exp_rdata);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        #1 reset = 1'b0;
        #2;
        checks++;
        if (gnt !== 3'b000 || done !== 3'b000 || err !== 1'b0 ||
            rdata !== 8'd0 || bus_start !== 1'b0 || bus_addr !== 8'd0 ||
            bus_wdata !== 8'd0 || bus_rw !== 1'b0) begin
            errs++;
            $display("FAIL reset: gnt=%b done=%b err=%b rdata=%h start=%b addr=%h wd=%h rw=%b exp all 0",
                     gnt, done, err, rdata, bus_start, bus_addr, bus_wdata, bus_rw);
        end
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        checks++;
        if (gnt !== 3'b000 || bus_start !== 1'b0) begin
            errs++;
            $display("FAIL reset_release: gnt=%b start=%b exp 000 0", gnt, bus_start);
        end
    endtask

    task automatic test_user_write();
        addr_a[1]  = 8'h21;
        wdata_a[1] = 8'h15;
        rw_a[1]    = 1'b1;
        drive_txn(3'b010, 3'b000, 5, 8'h5a, 1'b0);
    endtask

    task automatic test_priority();
        for (int i = 0; i < 3; i++) rw_a[i] = 1'b1;
        drive_txn(3'b111, 3'b110, 3, 8'h00, 1'b0);
        drive_txn(3'b110, 3'b110, 2, 8'h00, 1'b0);
        drive_txn(3'b110, 3'b110, 2, 8'h00, 1'b0);
        drive_txn(3'b110, 3'b110, 2, 8'h00, 1'b0);
        drive_txn(3'b110, 3'b000, 2, 8'h00, 1'b0);
    endtask

    task automatic test_read();
        rw_a[2] = 1'b0;
        drive_txn(3'b100, 3'b000, 3, 8'h37, 1'b0);
    endtask

    task automatic test_timeout();
        rw_a[1] = 1'b0;
        drive_txn(3'b010, 3'b000, 0, 8'haa, 1'b0);
    endtask

    task automatic test_drop();
        rw_a[1] = 1'b0;
        drive_txn(3'b010, 3'b000, 4, 8'h6c, 1'b1);
    endtask

    task automatic test_reset_wait();
        int bad;
        bad = 0;
        req = 3'b010;
        @(negedge clk);
        @(negedge clk);
        req = 3'b000;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        #1;
        checks++;
        if (gnt !== 3'b000 || done !== 3'b000 || err !== 1'b0 ||
            rdata !== 8'd0 || bus_start !== 1'b0 || bus_addr !== 8'd0 ||
            bus_wdata !== 8'd0 || bus_rw !== 1'b0) begin
            errs++;
            $display("FAIL reset_wait: gnt=%b done=%b err=%b rdata=%h start=%b addr=%h exp all 0",
                     gnt, done, err, rdata, bus_start, bus_addr);
        end
        fav_user  = 1;
        exp_rdata = 8'd0;
        @(negedge clk);
        reset     = 1'b1;
        bus_fin   = 1'b1;
        bus_rdata = 8'hee;
        @(negedge clk);
        bus_fin = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (done !== 3'b000 || gnt !== 3'b000 || bus_start !== 1'b0 ||
                rdata !== 8'd0)
                bad++;
            @(negedge clk);
        end
        checks++;
        if (bad != 0) begin
            errs++;
            $display("FAIL post_reset: %0d active cycles, exp 0", bad);
        end
    endtask

    task automatic test_back_to_back();
        logic [2:0] r;
        logic [2:0] ra;
        for (int n = 0; n < 25; n++) begin
            for (int i = 0; i < 3; i++) begin
                addr_a[i]  = 8'($urandom);
                wdata_a[i] = 8'($urandom);
                rw_a[i]    = 1'($urandom);
            end
            r  = 3'($urandom_range(1, 7));
            ra = (n == 24) ? 3'b000 : 3'($urandom);
            drive_txn(r, ra, int'($urandom_range(1, 6)),
                      8'($urandom), 1'($urandom));
        end
    endtask

    initial begin
        for (int i = 0; i < 3; i++) begin
            addr_a[i]  = 8'd0;
            wdata_a[i] = 8'd0;
            rw_a[i]    = 1'b1;
        end
        test_reset();
        test_user_write();
        test_priority();
        test_read();
        test_timeout();
        test_drop();
        test_reset_wait();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
